micro_op_queue: RTL and testbench

Parametrised micro-op buffer between decode and rename. Each cycle it accepts one decode group of up to IN_WIDTH instructions, each expanded to up to MOP_MAX micro-ops. It compacts the valid micro-ops into program order in a circular FIFO and issues up to OUT_WIDTH micro-ops per cycle. It generalises the fixed 3-micro-op / DECODE_WIDTH split path with configurable widths, depth, backpressure, serialization isolation and flush.

---
 rtl/micro_op_queue_if.sv | 34 +++
 rtl/micro_op_queue.sv | 115 +++++++++++
 tb/tb_micro_op_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_op_queue_if.sv
// Decode-to-rename micro-op bus: grouped input slots, issue window and flush.
// The master side is the decode/rename environment; the slave side is the queue.
interface micro_op_queue_if #(
   parameter int IN_WIDTH     = 2,
   parameter int MOP_MAX      = 3,
   parameter int OUT_WIDTH    = 2,
   parameter int DEPTH        = 8,
   parameter int PAYLOAD_BITS = 64
);
   localparam int SLOTS = IN_WIDTH * MOP_MAX;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                              flush;
   logic                              inValid;
   logic                              inReady;
   logic [SLOTS-1:0]                  inOpValid;
   logic [SLOTS-1:0]                  inOpSerialized;
   logic [SLOTS*PAYLOAD_BITS-1:0]     inOpPayload;
   logic [OUT_WIDTH-1:0]              outValid;
   logic [OUT_WIDTH-1:0]              outSerialized;
   logic [OUT_WIDTH*PAYLOAD_BITS-1:0] outPayload;
   logic                              outReady;
   logic [CNT_W-1:0]                  count;

   modport master (
      output flush, inValid, inOpValid, inOpSerialized, inOpPayload, outReady,
      input  inReady, outValid, outSerialized, outPayload, count
   );

   modport slave (
      input  flush, inValid, inOpValid, inOpSerialized, inOpPayload, outReady,
      output inReady, outValid, outSerialized, outPayload, count
   );
endinterface

// File: rtl/micro_op_queue.sv
// Micro-op buffer: compacts valid slots of a decode group into a circular FIFO
// and issues up to OUT_WIDTH ops per cycle, isolating serialized ops.
module micro_op_queue #(
   parameter int IN_WIDTH     = 2,
   parameter int MOP_MAX      = 3,
   parameter int OUT_WIDTH    = 2,
   parameter int DEPTH        = 8,
   parameter int PAYLOAD_BITS = 64
) (
   input logic              clk,
   input logic              rst_n,
   micro_op_queue_if.slave  bus
);
   localparam int SLOTS = IN_WIDTH * MOP_MAX;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]        head, tail;
   logic [CNT_W-1:0]        count;
   logic                    mem_ser [DEPTH];
   logic [PAYLOAD_BITS-1:0] mem_pay [DEPTH];

   logic [PTR_W-1:0] slot_off [SLOTS];
   logic [PTR_W-1:0] rd_idx   [OUT_WIDTH];
   logic [CNT_W-1:0] push_cnt, issue_cnt, pop_cnt;
   logic             stop, in_ready, do_push, do_pop;

   // Each valid slot lands at tail plus the number of valid slots below it.
   // NOTE: blocking '=' is correct here: push_cnt is a running sum inside one
   // combinational evaluation, not state carried across clock edges.
   always_comb begin
      push_cnt = '0;
      for (int s = 0; s < SLOTS; s++) begin
         slot_off[s] = push_cnt[PTR_W-1:0];
         if (bus.inOpValid[s]) push_cnt = push_cnt + CNT_W'(1);
      end
   end

   // Window ends before any serialized op past slot 0, and right after one in slot 0.
   // NOTE: every variable gets a value before the loop so no path leaves one
   // unassigned; otherwise synthesis infers latches.
   always_comb begin
      issue_cnt = '0;
      stop      = 1'b0;
      for (int k = 0; k < OUT_WIDTH; k++) begin
         rd_idx[k] = head + PTR_W'(k);
         if (!stop && (CNT_W'(k) < count)) begin
            if (mem_ser[rd_idx[k]] && k != 0) begin
               stop = 1'b1;
            end else begin
               issue_cnt = CNT_W'(k + 1);
               stop      = mem_ser[rd_idx[k]];
            end
         end else begin
            stop = 1'b1;
         end
      end
   end

   always_comb begin
      bus.outValid      = '0;
      bus.outSerialized = '0;
      bus.outPayload    = '0;
      for (int k = 0; k < OUT_WIDTH; k++) begin
         bus.outValid[k] = CNT_W'(k) < issue_cnt;
         if (bus.outValid[k]) begin
            bus.outSerialized[k]                               = mem_ser[rd_idx[k]];
            bus.outPayload[k*PAYLOAD_BITS +: PAYLOAD_BITS]     = mem_pay[rd_idx[k]];
         end
      end
   end

   assign in_ready    = (CNT_W'(DEPTH) - count) >= CNT_W'(SLOTS);
   assign do_push     = bus.inValid & in_ready & ~bus.flush;
   assign do_pop      = bus.outReady & ~bus.flush;
   assign pop_cnt     = do_pop ? issue_cnt : '0;
   assign bus.inReady = in_ready;
   assign bus.count   = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_cnt[PTR_W-1:0];
         if (do_push) tail <= tail + push_cnt[PTR_W-1:0];
         count <= count + (do_push ? push_cnt : '0) - pop_cnt;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read once
   // count covers them and outputs are masked by outValid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         for (int s = 0; s < SLOTS; s++) begin
            if (bus.inOpValid[s]) begin
               mem_ser[tail + slot_off[s]] <= bus.inOpSerialized[s];
               mem_pay[tail + slot_off[s]] <= bus.inOpPayload[s*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
         end
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count <= CNT_W'(DEPTH));
   a_out_contig: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.outValid & (bus.outValid + OUT_WIDTH'(1))) == '0);
   a_push_ready: assert property (@(posedge clk) disable iff (!rst_n)
      !(do_push && !in_ready));
endmodule

// File: tb/tb_micro_op_queue.sv
// Self-checking bench for micro_op_queue: directed scenarios plus a random soak,
// all compared every cycle against a queue-based reference model.
module tb_micro_op_queue;
   localparam int IW = 2, MM = 3, OW = 2, D = 8, PB = 64;
   localparam int SLOTS = IW * MM;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   micro_op_queue_if #(.IN_WIDTH(IW), .MOP_MAX(MM), .OUT_WIDTH(OW),
                       .DEPTH(D), .PAYLOAD_BITS(PB)) bus ();

   micro_op_queue #(.IN_WIDTH(IW), .MOP_MAX(MM), .OUT_WIDTH(OW),
                    .DEPTH(D), .PAYLOAD_BITS(PB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic          ser;
      logic [PB-1:0] pay;
   } mop_t;

   mop_t        q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned total_pop = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Issue window from the rules: up to OW ops, a serialized op always alone.
   function automatic int model_window();
      int n;
      n = (q.size() < OW) ? q.size() : OW;
      if (n > 0 && q[0].ser) return 1;
      for (int k = 1; k < n; k++) if (q[k].ser) return k;
      return n;
   endfunction

   function automatic bit model_ready();
      return (D - q.size()) >= SLOTS;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || bus.flush) begin
         q.delete();
      end else begin
         bit rdy;
         int n;
         rdy = model_ready();
         n   = model_window();
         if (bus.outReady) begin
            repeat (n) void'(q.pop_front());
            total_pop += n;
         end
         if (bus.inValid && rdy)
            for (int s = 0; s < SLOTS; s++)
               if (bus.inOpValid[s])
                  q.push_back({bus.inOpSerialized[s], bus.inOpPayload[s*PB +: PB]});
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         int n;
         n = model_window();
         check("inReady", 64'(bus.inReady), 64'(model_ready()));
         check("count", 64'(bus.count), 64'(q.size()));
         for (int k = 0; k < OW; k++) begin
            check("outValid", 64'(bus.outValid[k]), 64'(k < n));
            if (k < n) begin
               check("outSerialized", 64'(bus.outSerialized[k]), 64'(q[k].ser));
               check("outPayload", bus.outPayload[k*PB +: PB], q[k].pay);
            end
         end
      end
   end

   task automatic idle();
      bus.flush          = 1'b0;
      bus.inValid        = 1'b0;
      bus.inOpValid      = '0;
      bus.inOpSerialized = '0;
      bus.inOpPayload    = '0;
      bus.outReady       = 1'b0;
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int s, input logic ser, input logic [PB-1:0] p);
      bus.inOpValid[s]            = 1'b1;
      bus.inOpSerialized[s]       = ser;
      bus.inOpPayload[s*PB +: PB] = p;
   endtask

   task automatic clear_group();
      bus.inValid        = 1'b0;
      bus.inOpValid      = '0;
      bus.inOpSerialized = '0;
      bus.inOpPayload    = '0;
   endtask

   localparam logic [PB-1:0] PA = 64'hAAAA_0000_0000_0001;
   localparam logic [PB-1:0] PBB = 64'hBBBB_0000_0000_0002;
   localparam logic [PB-1:0] PC = 64'hCCCC_0000_0000_0003;
   localparam logic [PB-1:0] PS = 64'h5555_0000_0000_0004;

   initial begin
      idle();
      step(2);
      rst_n = 1'b1;
      chk_en = 1'b1;
      check("reset_count", 64'(bus.count), 64'd0);
      check("reset_outValid", 64'(bus.outValid), 64'd0);
      check("reset_inReady", 64'(bus.inReady), 64'd1);

      // Reset mid-traffic with five ops buffered.
      bus.inValid = 1'b1;
      for (int s = 0; s < 5; s++) set_slot(s, 1'b0, 64'(s + 100));
      step();
      clear_group();
      check("pre_reset_count", 64'(bus.count), 64'd5);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      check("post_reset_count", 64'(bus.count), 64'd0);
      check("post_reset_outValid", 64'(bus.outValid), 64'd0);
      check("post_reset_inReady", 64'(bus.inReady), 64'd1);

      // Compaction of a sparse group.
      bus.inValid  = 1'b1;
      bus.outReady = 1'b1;
      set_slot(0, 1'b0, PA);
      set_slot(1, 1'b0, PBB);
      set_slot(3, 1'b0, PC);
      step();
      clear_group();
      check("cmp_valid0", 64'(bus.outValid), 64'b11);
      check("cmp_pay0", bus.outPayload[0 +: PB], PA);
      check("cmp_pay1", bus.outPayload[PB +: PB], PBB);
      step();
      check("cmp_valid1", 64'(bus.outValid), 64'b01);
      check("cmp_pay2", bus.outPayload[0 +: PB], PC);
      step();
      check("cmp_empty", 64'(bus.count), 64'd0);

      // Backpressure and inReady threshold.
      bus.outReady = 1'b0;
      bus.inValid  = 1'b1;
      for (int s = 0; s < SLOTS; s++) set_slot(s, 1'b0, 64'(s + 200));
      step();
      clear_group();
      check("bp_count6", 64'(bus.count), 64'd6);
      check("bp_ready6", 64'(bus.inReady), 64'd0);
      bus.outReady = 1'b1;
      step();
      check("bp_count4", 64'(bus.count), 64'd4);
      check("bp_ready4", 64'(bus.inReady), 64'd0);
      step();
      check("bp_count2", 64'(bus.count), 64'd2);
      check("bp_ready2", 64'(bus.inReady), 64'd1);
      bus.outReady = 1'b0;
      bus.flush    = 1'b1;
      step();
      bus.flush = 1'b0;

      // Serialized op isolation.
      bus.inValid = 1'b1;
      set_slot(0, 1'b0, PA);
      set_slot(1, 1'b1, PS);
      set_slot(2, 1'b0, PBB);
      step();
      clear_group();
      check("ser_valid_a", 64'(bus.outValid), 64'b01);
      check("ser_pay_a", bus.outPayload[0 +: PB], PA);
      bus.outReady = 1'b1;
      step();
      check("ser_valid_s", 64'(bus.outValid), 64'b01);
      check("ser_flag_s", 64'(bus.outSerialized), 64'b01);
      check("ser_pay_s", bus.outPayload[0 +: PB], PS);
      step();
      check("ser_valid_b", 64'(bus.outValid), 64'b01);
      check("ser_flag_b", 64'(bus.outSerialized), 64'b00);
      check("ser_pay_b", bus.outPayload[0 +: PB], PBB);
      step();
      check("ser_empty", 64'(bus.count), 64'd0);

      // Flush colliding with push and pop.
      bus.outReady = 1'b0;
      bus.inValid  = 1'b1;
      for (int s = 0; s < 3; s++) set_slot(s, 1'b0, 64'(s + 300));
      step();
      clear_group();
      check("fl_count3", 64'(bus.count), 64'd3);
      bus.inValid = 1'b1;
      for (int s = 0; s < 4; s++) set_slot(s, 1'b0, 64'(s + 400));
      bus.outReady = 1'b1;
      bus.flush    = 1'b1;
      step();
      idle();
      check("fl_count0", 64'(bus.count), 64'd0);
      check("fl_outValid", 64'(bus.outValid), 64'd0);
      step(3);
      check("fl_still_empty", 64'(bus.count), 64'd0);

      // Random soak with sparse serialized ops and rare flushes.
      for (int c = 0; c < 2000; c++) begin
         bus.flush    = ($urandom_range(0, 199) == 0);
         bus.inValid  = ($urandom_range(0, 9) < 7);
         bus.outReady = ($urandom_range(0, 9) < 6);
         for (int s = 0; s < SLOTS; s++) begin
            bus.inOpValid[s]            = $urandom_range(0, 1) == 1;
            bus.inOpSerialized[s]       = $urandom_range(0, 9) == 0;
            bus.inOpPayload[s*PB +: PB] = {$urandom, $urandom};
         end
         step();
      end
      idle();
      bus.outReady = 1'b1;
      step(20);
      check("soak_drained", 64'(bus.count), 64'd0);
      check("head_wraps_ge_100", 64'(total_pop / D >= 100), 64'd1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
